// File: rtl/acc_ctrl_gen_pkg.sv
// Shared definitions for the PE control-word issuer and its consumers:
// control-bit positions and the issuer FSM state encoding.
package acc_ctrl_gen_pkg;

  localparam int unsigned CTRL_VALID   = 0;
  localparam int unsigned CTRL_TAP_LSB = 1;
  localparam int unsigned CTRL_TAP_MSB = 6;
  localparam int unsigned CTRL_LAST    = 7;
  localparam int unsigned CTRL_FIRST   = 8;

  localparam int unsigned CTRL_TAP_W = CTRL_TAP_MSB - CTRL_TAP_LSB + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

endpackage

// File: rtl/acc_ctrl_cnt.sv
// Nested tap/kernel counter: tap advances on en, wraps at klen-1 and then
// advances the kernel count; exposes first/last/terminal flags combinationally.
module acc_ctrl_cnt #(
  parameter int unsigned KLEN_WIDTH = 8,
  parameter int unsigned NK_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic [KLEN_WIDTH-1:0] klen,
  input  logic [NK_WIDTH-1:0]   nk,
  output logic [KLEN_WIDTH-1:0] tap,
  output logic                  tap_first,
  output logic                  tap_last,
  output logic                  job_last
);

  logic [NK_WIDTH-1:0] kern;
  logic                kern_last;

  assign tap_first = (tap == '0);
  assign tap_last  = (tap == klen - KLEN_WIDTH'(1));
  assign kern_last = (kern == nk - NK_WIDTH'(1));
  assign job_last  = tap_last & kern_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap  <= '0;
      kern <= '0;
    end else if (clr) begin
      tap  <= '0;
      kern <= '0;
    end else if (en) begin
      if (tap_last) begin
        tap  <= '0;
        kern <= kern_last ? '0 : kern + NK_WIDTH'(1);
      end else begin
        tap <= tap + KLEN_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/acc_ctrl_gen.sv
// Issues one PE control word plus matching RAM read strobe/address per kernel
// tap for a configured job, with a start/busy/done handshake to the scheduler.
module acc_ctrl_gen
  import acc_ctrl_gen_pkg::*;
#(
  parameter int unsigned CTRL_WIDTH = 9,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned KLEN_WIDTH = 8,
  parameter int unsigned NK_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [KLEN_WIDTH-1:0] cfg_klen,
  input  logic [NK_WIDTH-1:0]   cfg_nk,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic                  stall,
  output logic [CTRL_WIDTH-1:0] ctrl,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  busy,
  output logic                  done
);

  state_t                state;
  logic [KLEN_WIDTH-1:0] klen_q;
  logic [NK_WIDTH-1:0]   nk_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  fin_wait;

  logic                  accept;
  logic                  issue;
  logic [KLEN_WIDTH-1:0] tap;
  logic                  tap_first;
  logic                  tap_last;
  logic                  job_last;
  logic [CTRL_WIDTH-1:0] word;

  assign accept = (state == IDLE) && start;
  assign issue  = (state == RUN) && !stall;

  acc_ctrl_cnt #(
    .KLEN_WIDTH(KLEN_WIDTH),
    .NK_WIDTH  (NK_WIDTH)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept),
    .en       (issue),
    .klen     (klen_q),
    .nk       (nk_q),
    .tap      (tap),
    .tap_first(tap_first),
    .tap_last (tap_last),
    .job_last (job_last)
  );

  always_comb begin
    word = '0;
    word[CTRL_VALID] = 1'b1;
    word[CTRL_TAP_MSB:CTRL_TAP_LSB] = CTRL_TAP_W'(tap);
    word[CTRL_LAST]  = tap_last;
    word[CTRL_FIRST] = tap_first;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      klen_q   <= '0;
      nk_q     <= '0;
      addr_q   <= '0;
      fin_wait <= 1'b0;
      ctrl     <= '0;
      rd_en    <= 1'b0;
      rd_addr  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      ctrl  <= '0;
      rd_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            klen_q   <= cfg_klen;
            nk_q     <= cfg_nk;
            addr_q   <= cfg_base;
            busy     <= 1'b1;
            fin_wait <= 1'b1;
            state    <= (cfg_klen == '0 || cfg_nk == '0) ? FIN : RUN;
          end
        end
        RUN: begin
          if (!stall) begin
            ctrl    <= word;
            rd_en   <= 1'b1;
            rd_addr <= addr_q;
            addr_q  <= addr_q + ADDR_WIDTH'(1);
            if (job_last) state <= FIN;
          end
        end
        FIN: begin
          // One quiet cycle after the last word, then a one-cycle done;
          // busy drops on the edge that clears done.
          if (fin_wait) begin
            fin_wait <= 1'b0;
          end else if (!done) begin
            done <= 1'b1;
          end else begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_ctrl_gen.sv
// Self-checking bench for acc_ctrl_gen: table of jobs with a scoreboard queue
// of expected words, plus stall, restart, FIN-stall and mid-job reset cases.
module tb_acc_ctrl_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] cfg_klen;
  logic [7:0] cfg_nk;
  logic [9:0] cfg_base;
  logic       stall;
  logic [8:0] ctrl;
  logic       rd_en;
  logic [9:0] rd_addr;
  logic       busy;
  logic       done;

  acc_ctrl_gen #(
    .CTRL_WIDTH(9),
    .ADDR_WIDTH(10),
    .KLEN_WIDTH(8),
    .NK_WIDTH  (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .cfg_klen(cfg_klen),
    .cfg_nk  (cfg_nk),
    .cfg_base(cfg_base),
    .stall   (stall),
    .ctrl    (ctrl),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int klen;
    int nk;
    int base;
    int stall_pre;
    int stall_at;
    int stall_len;
    int restart_at;
    int rst_at;
    int exp_words;
    int exp_first;
    int exp_last;
    int exp_lat;
  } vec_t;

  typedef struct {
    logic [8:0] ctrl;
    logic [9:0] addr;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_job(input int klen, input int nk, input int base);
    exp_t e;
    int   idx = 0;
    for (int k = 0; k < nk; k++) begin
      for (int t = 0; t < klen; t++) begin
        e.ctrl = 9'h001 | (9'(t % 64) << 1);
        if (t == klen - 1) e.ctrl = e.ctrl | 9'h080;
        if (t == 0)        e.ctrl = e.ctrl | 9'h100;
        e.addr = 10'((base + idx) % 1024);
        idx++;
        q.push_back(e);
      end
    end
  endtask

  task automatic run_job(input vec_t v);
    int   wcnt = 0, fcnt = 0, lcnt = 0;
    int   start_cyc = 0, lat = 0;
    int   stall_rem = 0;
    bit   stall_fired = 0, restart_fired = 0, got_done = 0, aborted = 0;
    exp_t e;
    push_job(v.klen, v.nk, v.base);
    @(negedge clk);
    cfg_klen = 8'(v.klen);
    cfg_nk   = 8'(v.nk);
    cfg_base = 10'(v.base);
    start    = 1'b1;
    stall    = (v.stall_pre != 0);
    for (int c = 0; c < 300 && !got_done; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 0) begin
        start_cyc = cyc;
        check("busy_after_start", 32'(busy), 32'd1);
      end
      if (stall_rem > 0) begin
        check("stall_quiet", 32'({rd_en, ctrl}), 32'd0);
        stall_rem--;
        if (stall_rem == 0) stall = 1'b0;
      end else if (rd_en) begin
        if (q.size() == 0) begin
          check("word_unexpected", 32'({rd_en, ctrl, rd_addr}), 32'd0);
        end else begin
          e = q.pop_front();
          check("word", 32'({rd_en, ctrl, rd_addr}), 32'({1'b1, e.ctrl, e.addr}));
        end
        wcnt++;
        if (ctrl[8]) fcnt++;
        if (ctrl[7]) lcnt++;
      end
      if (done) begin
        got_done = 1;
        lat = cyc - start_cyc;
      end
      if (!stall_fired && v.stall_len > 0 && wcnt == v.stall_at) begin
        stall_fired = 1;
        stall       = 1'b1;
        stall_rem   = v.stall_len;
      end
      if (!restart_fired && v.restart_at >= 0 && wcnt == v.restart_at) begin
        restart_fired = 1;
        start    = 1'b1;
        cfg_klen = 8'd1;
        cfg_nk   = 8'd1;
        cfg_base = 10'h000;
      end
      if (v.rst_at >= 0 && wcnt == v.rst_at) begin
        rst = 1'b1;
        #1;
        check("rst_async_outputs", 32'({ctrl, rd_en, rd_addr, busy, done}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check("rst_no_done", 32'({busy, done, rd_en}), 32'd0);
        end
        q.delete();
        aborted = 1;
        break;
      end
    end
    stall = 1'b0;
    start = 1'b0;
    check("word_count", 32'(wcnt), 32'(v.exp_words));
    check("first_count", 32'(fcnt), 32'(v.exp_first));
    check("last_count", 32'(lcnt), 32'(v.exp_last));
    check("done_seen", 32'(got_done), 32'(v.exp_lat >= 0));
    if (!aborted) begin
      if (got_done) check("done_latency", 32'(lat), 32'(v.exp_lat));
      check("queue_empty", 32'(q.size()), 32'd0);
      q.delete();
      @(negedge clk);
      check("idle_after_done", 32'({busy, done}), 32'd0);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("tail_quiet", 32'({done, rd_en}), 32'd0);
      end
    end
  endtask

  vec_t vecs[11];

  initial begin
    //           klen nk base  pre at len rs rst  wds fst lst lat
    vecs[0]  = '{3,  2, 'h010, 0, -1, 0, -1, -1,  6,  2,  2,  8};
    vecs[1]  = '{1,  4, 'h100, 0, -1, 0, -1, -1,  4,  4,  4,  6};
    vecs[2]  = '{4,  1, 'h200, 0,  2, 3, -1, -1,  4,  1,  1,  9};
    vecs[3]  = '{0,  5, 'h000, 0, -1, 0, -1, -1,  0,  0,  0,  2};
    vecs[4]  = '{5,  0, 'h000, 0, -1, 0, -1, -1,  0,  0,  0,  2};
    vecs[5]  = '{4,  1, 'h3FE, 0, -1, 0,  2, -1,  4,  1,  1,  6};
    vecs[6]  = '{2,  2, 'h050, 1,  0, 2, -1, -1,  4,  2,  2,  8};
    vecs[7]  = '{2,  2, 'h060, 0,  4, 6, -1, -1,  4,  2,  2,  6};
    vecs[8]  = '{70, 1, 'h000, 0, -1, 0, -1, -1, 70,  1,  1, 72};
    vecs[9]  = '{8,  2, 'h000, 0, -1, 0, -1,  5,  5,  1,  0, -1};
    vecs[10] = '{2,  1, 'h020, 0, -1, 0, -1, -1,  2,  1,  1,  4};

    rst      = 1'b1;
    start    = 1'b0;
    stall    = 1'b0;
    cfg_klen = '0;
    cfg_nk   = '0;
    cfg_base = '0;
    repeat (2) @(negedge clk);
    check("reset_state", 32'({ctrl, rd_en, rd_addr, busy, done}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", 32'({ctrl, rd_en, busy, done}), 32'd0);

    for (int i = 0; i < 11; i++) run_job(vecs[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/acc_ctrl_gen.md
Name: acc_ctrl_gen

Overview:
- Issuer (transmitting end) of the 9-bit PE control word consumed by the multiply-accumulate datapath and accumulator.
- For a configured job, emits one control word per kernel tap, in order:
  - valid on every tap;
  - first on tap 0 of each kernel;
  - last on the final tap of each kernel.
- Emits the matching weight/activation RAM read strobe and address in the same cycle.
- Sits between the layer scheduler (start/done handshake) and the PE column. The consumer applies its own RAM_READ_LATENCY+2 delay, so ctrl and rd_en leave this block aligned.

Parameters:
- CTRL_WIDTH, 9, control word width; fixed bit layout below, must be >= 9.
- ADDR_WIDTH, 10, RAM read address width.
- KLEN_WIDTH, 8, width of the taps-per-kernel count.
- NK_WIDTH, 8, width of the kernel-count field.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  job request; accepted only in IDLE
- cfg_klen  in  KLEN_WIDTH  taps per kernel; sampled on accepted start
- cfg_nk  in  NK_WIDTH  kernels in job; sampled on accepted start
- cfg_base  in  ADDR_WIDTH  first read address; sampled on accepted start
- stall  in  1  downstream hold; no word issued while high
- ctrl  out  CTRL_WIDTH  control word to PE/accumulator
- rd_en  out  1  RAM read strobe, equals ctrl[0]
- rd_addr  out  ADDR_WIDTH  RAM read address
- busy  out  1  high from accepted start until done pulse, inclusive
- done  out  1  single-cycle job-complete pulse

Behaviour:
- Control word layout:
  - ctrl[0] valid;
  - ctrl[6:1] tap index modulo 64 (debug only);
  - ctrl[7] last;
  - ctrl[8] first;
  - bits above 8 are zero.
- All outputs are registered. Reset (async assert) forces all of the following, and the FSM goes to IDLE:
  - ctrl = 0, rd_en = 0, rd_addr = 0, busy = 0, done = 0;
  - tap counter, kernel counter and latched config = 0.
- FSM states: IDLE, RUN, FIN.
  - IDLE: start=1 at edge N → latch cfg, busy=1 after edge N.
    - If cfg_klen==0 or cfg_nk==0, go to FIN; no word is issued.
    - Otherwise go to RUN. The first word (first=1, valid=1, rd_addr=cfg_base) is visible after edge N+1.
  - RUN, per edge with stall=0:
    - Issue a word for the current (kernel k, tap t).
    - first = (t==0); last = (t==klen-1). klen==1 gives first=last=1 on every word.
    - rd_addr increments by 1 per issued word, wrapping modulo 2^ADDR_WIDTH.
    - t wraps to 0 and k increments when last is issued.
    - After the last word of kernel nk-1, go to FIN.
  - RUN, per edge with stall=1:
    - ctrl=0 and rd_en=0 on the next cycle.
    - Counters and rd_addr hold.
    - A stalled cycle never drops or duplicates a tap.
  - FIN: done=1 for exactly one cycle; busy deasserts in the same edge that clears done; return to IDLE.
- Totals:
  - Exactly klen*nk valid words per job; exactly nk first bits and nk last bits.
  - Unstalled job: done visible klen*nk+1 cycles after the first word.
- Boundary conditions:
  - start while busy is ignored; cfg changes while busy are ignored.
  - start and stall both high in IDLE: start is still accepted; stall only gates issue in RUN.
  - stall during FIN has no effect on done.
  - rst mid-job: immediate abort to the reset values; no done pulse; next start begins fresh.
  - Tap-index debug field wraps every 64 taps independently of last.

Decomposition:
- Shared package (alongside defs): control-bit index constants CTRL_VALID=0, CTRL_LAST=7, CTRL_FIRST=8, CTRL_TAP_LSB=1, CTRL_TAP_MSB=6; FSM state enum typedef {IDLE, RUN, FIN}. The accumulator and this block both use these constants.
- One natural sub-module: acc_ctrl_cnt, a nested tap/kernel counter with enable, wrap and terminal-count outputs. The FSM and output registers stay in the top.

Test Plan:
- Basic job:
  - Stimulus: klen=3, nk=2, base=0x010, no stall.
  - Response: 6 valid words with first on words 0 and 3, last on words 2 and 5; rd_addr 0x010..0x015; done 7 cycles after the first word; busy low after done.
- Single-tap kernels:
  - Stimulus: klen=1, nk=4.
  - Response: 4 words, each with first=last=valid=1.
- Stall mid-job:
  - Stimulus: klen=4, nk=1; stall high for 3 cycles after the second word.
  - Response: ctrl=0 and rd_en=0 for 3 cycles; the third word resumes at tap 2, rd_addr base+2; 4 valid words total.
- Zero-length jobs:
  - Stimulus: klen=0, nk=5; then klen=5, nk=0.
  - Response: each job issues no valid word; done pulses 2 cycles after start.
- Address wrap and busy start:
  - Stimulus: ADDR_WIDTH=10, base=0x3FE, klen=4, nk=1; a second start is pulsed mid-job.
  - Response: rd_addr 0x3FE, 0x3FF, 0x000, 0x001; the second start is ignored (only one done).
- Reset mid-job:
  - Stimulus: klen=8, nk=2; assert rst asynchronously after the 5th word.
  - Response: all outputs 0 immediately, no done; a following start with klen=2, nk=1 issues exactly 2 words.
